gold_router: RTL and testbench
==============================

Name: gold_router

Overview:
- 5-port mesh NoC router: up (north), down (south), left (west), right (east) and NIC (local PE).
- 64-bit single-flit packets, two virtual channels (even/odd) time-multiplexed by a global polarity bit.
- XY dimension-order routing with per-input, per-VC one-flit buffers, per-output, per-VC one-flit buffers and round-robin output arbitration.
- Instantiated once per mesh node; the NIC side takes polarity from polarity_to_NIC.

Parameters:
- DW, 64, flit width.
- NPORT, 5, port count (fixed order: up, down, left, right, NIC).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-low reset.
- {up,down,left,right,NIC}_si  in  1 each  upstream send/valid.
- {up,down,left,right,NIC}_di  in  64 each  upstream flit.
- {up,down,left,right,NIC}_ri  out  1 each  ready to upstream: input buffer for current-polarity VC empty.
- {up,down,left,right,NIC}_so  out  1 each  send/valid to downstream.
- {up,down,left,right,NIC}_do  out  64 each  flit to downstream.
- {up,down,left,right,NIC}_ro  in  1 each  downstream ready.
- polarity_to_NIC  out  1  current polarity.

Behaviour:
- Reset:
  - Clocking edge with reset low clears all 20 buffer-full flags and the round-robin pointers, and sets polarity=0.
  - After reset, all so=0, all do=0, all ri=1.
- Polarity: toggles every clock edge after reset. Links carry VC == polarity; internal switching uses VC == ~polarity.
- Flit header:
  - [63] VC.
  - [55:52] X field = {xdir, 3-bit xhops}; xdir 0=east/right, 1=west/left.
  - [51:48] Y field = {ydir, 3-bit yhops}; ydir 0=north/up, 1=south/down.
  - All other bits are passed through unchanged.
- Route computation (XY):
  - xhops != 0 -> right/left by xdir.
  - else yhops != 0 -> up/down by ydir.
  - else NIC.
- Hop update:
  - On an X hop, xhops decrements by 1; on a Y hop, yhops decrements by 1. The decrement is applied on transfer into the output buffer.
  - NIC-bound flits are not modified.
- Input capture: at an edge where si=1, di[63]==polarity and in_buf[port][polarity] is empty, store di and set full. Otherwise di is ignored, so an si held for 2 cycles is captured exactly once.
- Switch stage (each edge, v = ~polarity):
  - Every full in_buf[i][v] requests its routed output o.
  - For each o whose out_buf[o][v] is empty, a 5-way round-robin arbiter grants one requester.
  - The granted flit moves to out_buf[o][v] with hops updated, and the in_buf is cleared.
  - The pointer moves to just past the winner. Initial priority order after reset: up, down, left, right, NIC.
- Output stage:
  - so = out_buf[o][polarity].full.
  - do = out_buf[o][polarity].data when so=1, else 0.
  - At an edge with so=1 and ro=1 the buffer clears. With ro=0 the flit holds and is retried at the next same-polarity cycle.
- Latency: a flit captured at edge E0 sits in the output buffer after E1 and appears on so/do during the cycle following E1. Minimum is 2 edges input-to-output.
- Simultaneous events:
  - Capture, switch and output drain of the same buffer never collide, because they operate on opposite VCs.
  - A buffer freed by switching may accept a new flit no earlier than the next same-polarity cycle.
- Reset mid-operation: all buffered flits are discarded and no partial output is produced.
- U-turns (output port == input port) are not generated by XY routing and need no special handling.

Decomposition:
- Package gold_router_pkg holds:
  - port index constants (UP=0, DOWN=1, LEFT=2, RIGHT=3, NIC=4);
  - header bit positions (VC_BIT=63, X_FIELD=55:52, Y_FIELD=51:48);
  - a 3-bit route-code enum.
- One sub-module, rr_arbiter5 (5 request bits -> one-hot grant, rotating pointer), instantiated once per output per VC (10 instances).

Test Plan:
- Down input, 0x8003_0000_0000_0000, si held 2 cycles -> up_so pulses once 2 edges after capture; up_do = 0x8002_0000_0000_0000.
- Right input, 0x000C_0000_0000_0000 (even VC) -> down_so asserts in an even-polarity cycle; down_do = 0x000B_0000_0000_0000.
- Left input 0x8000_0000_0000_0000 -> NIC_do = 0x8000_0000_0000_0000 unmodified. Left input 0x8033_... -> right_do = 0x8023_0000_0000_0000.
- Conflict: NIC 0x8022_... and left 0x8033_... arrive the same edge, both routed right:
  - NIC-routed flit appears as right_do 0x8012_0000_0000_0000;
  - left-routed flit appears as 0x8023_0000_0000_0000;
  - first grant follows the pointer, and the second appears exactly 2 cycles after the first.
- Blocking: right_ro=0, send 0x0033_... then 0x8033_... from left:
  - right_so stays high with do held, and left_ri drops for the blocked VC;
  - raise right_ro for one same-polarity cycle -> that flit drains and the next queued flit follows.
- Reset asserted while flits are buffered -> next edge all so=0, do=0, ri=1, polarity_to_NIC=0, then toggles.

Source files
------------

// File: rtl/gold_router_pkg.sv
// rtl/gold_router_pkg.sv - shared constants, route codes and header helpers for gold_router
package gold_router_pkg;

    localparam int DW    = 64;
    localparam int NPORT = 5;
    localparam int NVC   = 2;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;
    localparam int NIC   = 4;

    localparam int VC_BIT = 63;
    localparam int X_HI   = 55;
    localparam int X_LO   = 52;
    localparam int Y_HI   = 51;
    localparam int Y_LO   = 48;

    // Encodings line up with the port indices so a route code doubles as an output index.
    typedef enum logic [2:0] {
        RT_UP    = 3'd0,
        RT_DOWN  = 3'd1,
        RT_LEFT  = 3'd2,
        RT_RIGHT = 3'd3,
        RT_NIC   = 3'd4
    } route_t;

    function automatic route_t route_of(input logic [DW-1:0] f);
        route_t r;
        if (f[X_HI-1:X_LO] != 3'd0) begin
            r = f[X_HI] ? RT_LEFT : RT_RIGHT;
        end else if (f[Y_HI-1:Y_LO] != 3'd0) begin
            r = f[Y_HI] ? RT_DOWN : RT_UP;
        end else begin
            r = RT_NIC;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] hop_update(input logic [DW-1:0] f, input route_t r);
        logic [DW-1:0] g;
        g = f;
        case (r)
            RT_LEFT, RT_RIGHT: g[X_HI-1:X_LO] = f[X_HI-1:X_LO] - 3'd1;
            RT_UP, RT_DOWN:    g[Y_HI-1:Y_LO] = f[Y_HI-1:Y_LO] - 3'd1;
            default:           g = f;
        endcase
        return g;
    endfunction

    function automatic logic vc_of(input logic [DW-1:0] f);
        return f[VC_BIT];
    endfunction

endpackage

// File: rtl/gold_router_if.sv
// rtl/gold_router_if.sv - the five link bundles of one mesh node
interface gold_router_if;
    import gold_router_pkg::*;

    logic          up_si, down_si, left_si, right_si, NIC_si;
    logic [DW-1:0] up_di, down_di, left_di, right_di, NIC_di;
    logic          up_ri, down_ri, left_ri, right_ri, NIC_ri;
    logic          up_so, down_so, left_so, right_so, NIC_so;
    logic [DW-1:0] up_do, down_do, left_do, right_do, NIC_do;
    logic          up_ro, down_ro, left_ro, right_ro, NIC_ro;

    modport slave (
        input  up_si, down_si, left_si, right_si, NIC_si,
        input  up_di, down_di, left_di, right_di, NIC_di,
        output up_ri, down_ri, left_ri, right_ri, NIC_ri,
        output up_so, down_so, left_so, right_so, NIC_so,
        output up_do, down_do, left_do, right_do, NIC_do,
        input  up_ro, down_ro, left_ro, right_ro, NIC_ro
    );

    modport master (
        output up_si, down_si, left_si, right_si, NIC_si,
        output up_di, down_di, left_di, right_di, NIC_di,
        input  up_ri, down_ri, left_ri, right_ri, NIC_ri,
        input  up_so, down_so, left_so, right_so, NIC_so,
        input  up_do, down_do, left_do, right_do, NIC_do,
        output up_ro, down_ro, left_ro, right_ro, NIC_ro
    );

endinterface

// File: rtl/gold_router_arb.sv
// rtl/gold_router_arb.sv - 5-way round-robin arbiter, pointer parks just past the last winner
module rr_arbiter5
    import gold_router_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NPORT-1:0] req,
    output logic [NPORT-1:0] grant
);

    logic [2:0] ptr;
    logic [2:0] win;
    logic [2:0] idx;
    logic [3:0] sum;
    logic       found;

    always_comb begin
        grant = '0;
        win   = ptr;
        found = 1'b0;
        idx   = 3'd0;
        sum   = 4'd0;
        for (int k = 0; k < NPORT; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= 3'd0;
        end else if (found) begin
            ptr <= (win == 3'd4) ? 3'd0 : win + 3'd1;
        end
    end

endmodule

// File: rtl/gold_router.sv
// rtl/gold_router.sv - 5-port XY mesh router, two VCs time-multiplexed by a global polarity bit
module gold_router
    import gold_router_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    gold_router_if.slave link,
    output logic         polarity_to_NIC
);

    logic             polarity;
    logic             sw_vc;
    logic [NPORT-1:0] si, ro, ri, so, cap, in_clear, sw_valid;
    logic [DW-1:0]    di       [NPORT];
    logic [DW-1:0]    dout     [NPORT];
    logic [NVC-1:0]   in_full  [NPORT];
    logic [NVC-1:0]   out_full [NPORT];
    logic [DW-1:0]    in_data  [NPORT][NVC];
    logic [DW-1:0]    out_data [NPORT][NVC];
    route_t           route    [NPORT];
    logic [NPORT-1:0] req      [NPORT];
    logic [NPORT-1:0] grant    [NPORT];
    logic [NPORT-1:0] grant_vc [NVC][NPORT];
    logic [DW-1:0]    sw_data  [NPORT];

    assign si = {link.NIC_si, link.right_si, link.left_si, link.down_si, link.up_si};
    assign ro = {link.NIC_ro, link.right_ro, link.left_ro, link.down_ro, link.up_ro};
    assign di[UP]    = link.up_di;
    assign di[DOWN]  = link.down_di;
    assign di[LEFT]  = link.left_di;
    assign di[RIGHT] = link.right_di;
    assign di[NIC]   = link.NIC_di;

    assign link.up_ri    = ri[UP];
    assign link.down_ri  = ri[DOWN];
    assign link.left_ri  = ri[LEFT];
    assign link.right_ri = ri[RIGHT];
    assign link.NIC_ri   = ri[NIC];
    assign link.up_so    = so[UP];
    assign link.down_so  = so[DOWN];
    assign link.left_so  = so[LEFT];
    assign link.right_so = so[RIGHT];
    assign link.NIC_so   = so[NIC];
    assign link.up_do    = dout[UP];
    assign link.down_do  = dout[DOWN];
    assign link.left_do  = dout[LEFT];
    assign link.right_do = dout[RIGHT];
    assign link.NIC_do   = dout[NIC];

    // Links run on the current polarity while the crossbar works the other VC.
    assign sw_vc           = ~polarity;
    assign polarity_to_NIC = polarity;

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            ri[i]    = ~in_full[i][polarity];
            cap[i]   = si[i] && (vc_of(di[i]) == polarity) && !in_full[i][polarity];
            so[i]    = out_full[i][polarity];
            dout[i]  = so[i] ? out_data[i][polarity] : '0;
            route[i] = route_of(in_data[i][sw_vc]);
        end
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            req[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                req[o][i] = in_full[i][sw_vc] && (int'(route[i]) == o);
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        for (genvar c = 0; c < NVC; c++) begin : g_vc
            localparam logic VC = (c == 1);
            logic [NPORT-1:0] arb_req;
            assign arb_req = (sw_vc == VC && !out_full[o][c]) ? req[o] : '0;
            rr_arbiter5 u_arb (
                .clk   (clk),
                .reset (reset),
                .req   (arb_req),
                .grant (grant_vc[c][o])
            );
        end
        assign grant[o] = grant_vc[sw_vc][o];
    end

    always_comb begin
        in_clear = '0;
        for (int o = 0; o < NPORT; o++) begin
            sw_valid[o] = |grant[o];
            sw_data[o]  = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (grant[o][i]) begin
                    sw_data[o]  = hop_update(in_data[i][sw_vc], route[i]);
                    in_clear[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            polarity <= 1'b0;
            for (int i = 0; i < NPORT; i++) begin
                in_full[i]  <= '0;
                out_full[i] <= '0;
            end
        end else begin
            polarity <= ~polarity;
            for (int i = 0; i < NPORT; i++) begin
                if (cap[i])           in_full[i][polarity]  <= 1'b1;
                if (in_clear[i])      in_full[i][sw_vc]     <= 1'b0;
                if (sw_valid[i])      out_full[i][sw_vc]    <= 1'b1;
                if (so[i] && ro[i])   out_full[i][polarity] <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset: the full flags gate every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            if (cap[i])      in_data[i][polarity] <= di[i];
            if (sw_valid[i]) out_data[i][sw_vc]   <= sw_data[i];
        end
    end

endmodule

// File: tb/tb_gold_router.sv
// tb/tb_gold_router.sv - scoreboard bench for gold_router with directed routing vectors
module tb_gold_router;
    import gold_router_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic polarity;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gold_router_if rif();

    gold_router dut (
        .clk             (clk),
        .reset           (reset),
        .link            (rif),
        .polarity_to_NIC (polarity)
    );

    logic        si   [NPORT];
    logic [63:0] di   [NPORT];
    logic        ro   [NPORT];
    logic        so_w [NPORT];
    logic        ri_w [NPORT];
    logic [63:0] do_w [NPORT];

    assign rif.up_si = si[UP];       assign rif.up_di = di[UP];       assign rif.up_ro = ro[UP];
    assign rif.down_si = si[DOWN];   assign rif.down_di = di[DOWN];   assign rif.down_ro = ro[DOWN];
    assign rif.left_si = si[LEFT];   assign rif.left_di = di[LEFT];   assign rif.left_ro = ro[LEFT];
    assign rif.right_si = si[RIGHT]; assign rif.right_di = di[RIGHT]; assign rif.right_ro = ro[RIGHT];
    assign rif.NIC_si = si[NIC];     assign rif.NIC_di = di[NIC];     assign rif.NIC_ro = ro[NIC];

    assign so_w[UP] = rif.up_so;       assign ri_w[UP] = rif.up_ri;       assign do_w[UP] = rif.up_do;
    assign so_w[DOWN] = rif.down_so;   assign ri_w[DOWN] = rif.down_ri;   assign do_w[DOWN] = rif.down_do;
    assign so_w[LEFT] = rif.left_so;   assign ri_w[LEFT] = rif.left_ri;   assign do_w[LEFT] = rif.left_do;
    assign so_w[RIGHT] = rif.right_so; assign ri_w[RIGHT] = rif.right_ri; assign do_w[RIGHT] = rif.right_do;
    assign so_w[NIC] = rif.NIC_so;     assign ri_w[NIC] = rif.NIC_ri;     assign do_w[NIC] = rif.NIC_do;

    string       pname [NPORT] = '{"up", "down", "left", "right", "nic"};
    logic [63:0] exp_q [NPORT][$];
    int          xfer_cnt  [NPORT] = '{default: 0};
    int          last_xfer [NPORT] = '{default: 0};
    int          prev_xfer [NPORT] = '{default: 0};

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pol(input logic b);
        for (int k = 0; k < 4; k++) begin
            if (polarity === b) return;
            tick();
        end
        check("wait_polarity", 64'(polarity), 64'(b));
    endtask

    task automatic send(input int p, input logic [63:0] d, input int hold, output int cap);
        int k;
        k = 0;
        while (!(polarity === d[63] && ri_w[p] === 1'b1) && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) check({"send_ready_", pname[p]}, 64'(ri_w[p]), 64'd1);
        si[p] = 1'b1;
        di[p] = d;
        tick();
        cap = cyc;
        for (int h = 1; h < hold; h++) tick();
        si[p] = 1'b0;
        di[p] = '0;
    endtask

    task automatic check_idle(input string tag);
        for (int p = 0; p < NPORT; p++) begin
            check({tag, "_so_", pname[p]}, 64'(so_w[p]), 64'd0);
            check({tag, "_do_", pname[p]}, do_w[p], 64'd0);
            check({tag, "_ri_", pname[p]}, 64'(ri_w[p]), 64'd1);
        end
        check({tag, "_polarity"}, 64'(polarity), 64'd0);
    endtask

    // Monitor: every accepted output transfer pops the next expected flit for that port.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int p = 0; p < NPORT; p++) begin
                    if (so_w[p] && ro[p]) begin
                        xfer_cnt[p]++;
                        prev_xfer[p] = last_xfer[p];
                        last_xfer[p] = cyc;
                        check({"link_vc_", pname[p]}, 64'(do_w[p][63]), 64'(polarity));
                        if (exp_q[p].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_%s: got %h expected no flit", pname[p], do_w[p]);
                        end else begin
                            e = exp_q[p].pop_front();
                            check({"flit_", pname[p]}, do_w[p], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cap;
        int saved;
        for (int p = 0; p < NPORT; p++) begin
            si[p] = 1'b0;
            di[p] = '0;
            ro[p] = 1'b1;
        end
        reset = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b1;

        // Y hop north, si held two cycles -> single output, 2-edge latency
        exp_q[UP].push_back(64'h8002_0000_0000_0000);
        send(DOWN, 64'h8003_0000_0000_0000, 2, cap);
        repeat (5) tick();
        check("up_pulse_count", 64'(xfer_cnt[UP]), 64'd1);
        check("up_latency", 64'(last_xfer[UP] - cap), 64'd1);

        // Even VC, Y hop south
        exp_q[DOWN].push_back(64'h000B_0000_0000_0000);
        send(RIGHT, 64'h000C_0000_0000_0000, 1, cap);
        repeat (5) tick();
        check("down_count", 64'(xfer_cnt[DOWN]), 64'd1);

        // Local delivery unmodified, then X hop east
        exp_q[NIC].push_back(64'h8000_0000_0000_0000);
        send(LEFT, 64'h8000_0000_0000_0000, 1, cap);
        exp_q[RIGHT].push_back(64'h8023_0000_0000_0000);
        send(LEFT, 64'h8033_0000_0000_0000, 1, cap);
        repeat (6) tick();

        // Conflict on right/VC1: pointer sits past left, so NIC wins first
        exp_q[RIGHT].push_back(64'h8012_0000_0000_0000);
        exp_q[RIGHT].push_back(64'h8023_0000_0000_0000);
        wait_pol(1'b1);
        si[NIC] = 1'b1;  di[NIC] = 64'h8022_0000_0000_0000;
        si[LEFT] = 1'b1; di[LEFT] = 64'h8033_0000_0000_0000;
        tick();
        si[NIC] = 1'b0;  di[NIC] = '0;
        si[LEFT] = 1'b0; di[LEFT] = '0;
        repeat (6) tick();
        check("conflict_count", 64'(xfer_cnt[RIGHT]), 64'd3);
        check("conflict_gap", 64'(last_xfer[RIGHT] - prev_xfer[RIGHT]), 64'd2);

        // Back-pressure on right
        ro[RIGHT] = 1'b0;
        exp_q[RIGHT].push_back(64'h0023_0000_0000_0001);
        exp_q[RIGHT].push_back(64'h8023_0000_0000_0002);
        exp_q[RIGHT].push_back(64'h0023_0000_0000_0003);
        send(LEFT, 64'h0033_0000_0000_0001, 1, cap);
        send(LEFT, 64'h8033_0000_0000_0002, 1, cap);
        send(LEFT, 64'h0033_0000_0000_0003, 1, cap);
        repeat (4) tick();
        wait_pol(1'b0);
        check("blk_so_even", 64'(so_w[RIGHT]), 64'd1);
        check("blk_do_even", do_w[RIGHT], 64'h0023_0000_0000_0001);
        check("blk_ri_even", 64'(ri_w[LEFT]), 64'd0);
        tick();
        check("blk_so_odd", 64'(so_w[RIGHT]), 64'd1);
        check("blk_do_odd", do_w[RIGHT], 64'h8023_0000_0000_0002);
        check("blk_ri_odd", 64'(ri_w[LEFT]), 64'd1);
        tick();
        check("blk_do_held", do_w[RIGHT], 64'h0023_0000_0000_0001);
        ro[RIGHT] = 1'b1;
        tick();
        ro[RIGHT] = 1'b0;
        wait_pol(1'b0);
        check("blk_next_do", do_w[RIGHT], 64'h0023_0000_0000_0003);
        check("blk_next_ri", 64'(ri_w[LEFT]), 64'd1);
        wait_pol(1'b1);
        ro[RIGHT] = 1'b1;
        repeat (4) tick();
        check("blk_total", 64'(xfer_cnt[RIGHT]), 64'd6);

        // Reset with flits buffered: all discarded
        ro[RIGHT] = 1'b0;
        send(LEFT, 64'h0033_0000_0000_00AA, 1, cap);
        send(LEFT, 64'h8033_0000_0000_00BB, 1, cap);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle("midreset");
        reset = 1'b1;
        ro[RIGHT] = 1'b1;
        saved = xfer_cnt[RIGHT];
        tick();
        check("pol_after_reset_1", 64'(polarity), 64'd1);
        tick();
        check("pol_after_reset_2", 64'(polarity), 64'd0);
        repeat (4) tick();
        check("no_output_after_reset", 64'(xfer_cnt[RIGHT]), 64'(saved));

        for (int p = 0; p < NPORT; p++) begin
            check({"queue_empty_", pname[p]}, 64'(exp_q[p].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
